// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC / instruction-fetch controller.
package pc_fetch_pkg;

   localparam int XLEN = 32;

   // EX-stage PC-source encoding; 2'b11 behaves like sequential.
   localparam logic [1:0] PCSRC_SEQ  = 2'b00;
   localparam logic [1:0] PCSRC_TGT  = 2'b01;
   localparam logic [1:0] PCSRC_JALR = 2'b10;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: sequential PC+4 or an EX redirect target, with the
// alignment check that swaps a misaligned target for the trap vector.
module pc_next_sel
   import pc_fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] TRAP_PC = 32'h0000_0100
) (
   input  logic [XLEN-1:0] pc,
   input  logic            redirect_valid,
   input  logic [1:0]      pc_src,
   input  logic [XLEN-1:0] pc_tgt,
   input  logic [XLEN-1:0] jalr_tgt,
   output logic            redirect,
   output logic            misaligned,
   output logic [XLEN-1:0] next_pc
);

   logic [XLEN-1:0] target;

   // Decode the redirect, form the target and pick the next PC.
   always_comb begin
      redirect = 1'b0;
      target   = pc_tgt;
      if (redirect_valid) begin
         case (pc_src)
            PCSRC_TGT: begin
               redirect = 1'b1;
               target   = pc_tgt;
            end
            PCSRC_JALR: begin
               redirect = 1'b1;
               // jalr clears bit 0 of the raw sum
               target   = jalr_tgt & ~XLEN'(1);
            end
            default: redirect = 1'b0;
         endcase
      end
      misaligned = redirect && (target[1:0] != 2'b00);
      if (!redirect)
         next_pc = pc + XLEN'(4);
      else if (misaligned)
         next_pc = TRAP_PC;
      else
         next_pc = target;
   end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC owner and fetch sequencer for a single-outstanding req/ack imem port.
// Handshake: a request is live while imem_req=1; imem_ack=1 in a cycle with
// imem_req=1 completes it in that cycle with imem_rdata valid. A live request
// keeps imem_addr stable until acked, regardless of stall or redirect.
// flush and misalign_trap pulse in the cycle after the redirect is sampled.
// Optional: define FETCH_PERF_EN to add fetch_count / redirect_count.
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] TRAP_PC  = 32'h0000_0100,
   parameter int          XLEN     = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            redirect_valid,
   input  logic [1:0]      pc_src,
   input  logic [XLEN-1:0] pc_tgt,
   input  logic [XLEN-1:0] jalr_tgt,
   input  logic            stall,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            if_valid,
   output logic [XLEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc,
   output logic            flush,
`ifdef FETCH_PERF_EN
   output logic [31:0]     fetch_count,
   output logic [31:0]     redirect_count,
`endif
   output logic            misalign_trap
);

   import pc_fetch_pkg::*;

   fetch_state_e    state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] addr_q;
   logic            skid_valid;
   logic [XLEN-1:0] skid_instr;
   logic [XLEN-1:0] skid_pc;
   logic            redirect;
   logic            misaligned;
   logic [XLEN-1:0] next_pc;
   logic            accept;
   logic            data_ok;
   logic            if_load;

   pc_next_sel #(.TRAP_PC(TRAP_PC)) u_next_sel (
      .pc             (pc),
      .redirect_valid (redirect_valid),
      .pc_src         (pc_src),
      .pc_tgt         (pc_tgt),
      .jalr_tgt       (jalr_tgt),
      .redirect       (redirect),
      .misaligned     (misaligned),
      .next_pc        (next_pc)
   );

   // Request generation: a new fetch only when not stalled and the skid is empty.
   always_comb begin
      imem_req  = 1'b0;
      imem_addr = pc;
      case (state)
         FETCH: imem_req = !stall && !skid_valid;
         WAIT, DRAIN: begin
            imem_req  = 1'b1;
            imem_addr = addr_q;
         end
         default: imem_req = 1'b0;
      endcase
   end

   assign accept  = imem_req && imem_ack;
   // Data returned while draining belongs to the wrong path.
   assign data_ok = accept && (state != DRAIN);
   assign if_load = !redirect && !stall && (skid_valid || data_ok);

   // Fetch FSM, PC, IF/ID register and skid buffer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= BOOT;
         pc            <= RESET_PC;
         addr_q        <= RESET_PC;
         skid_valid    <= 1'b0;
         skid_instr    <= '0;
         skid_pc       <= '0;
         if_valid      <= 1'b0;
         if_instr      <= '0;
         if_pc         <= '0;
         flush         <= 1'b0;
         misalign_trap <= 1'b0;
      end else begin
         flush         <= redirect;
         misalign_trap <= redirect && misaligned;
         if (redirect) begin
            pc         <= next_pc;
            if_valid   <= 1'b0;
            skid_valid <= 1'b0;
            if (imem_req && !imem_ack) begin
               state  <= DRAIN;
               addr_q <= imem_addr;
            end else begin
               state <= FETCH;
            end
         end else begin
            if (!stall) begin
               if (skid_valid) begin
                  if_valid   <= 1'b1;
                  if_instr   <= skid_instr;
                  if_pc      <= skid_pc;
                  skid_valid <= 1'b0;
               end else if (data_ok) begin
                  if_valid <= 1'b1;
                  if_instr <= imem_rdata;
                  if_pc    <= imem_addr;
               end else begin
                  if_valid <= 1'b0;
               end
            end else if (data_ok) begin
               skid_valid <= 1'b1;
               skid_instr <= imem_rdata;
               skid_pc    <= imem_addr;
            end
            case (state)
               BOOT: state <= FETCH;
               FETCH: begin
                  if (imem_req) begin
                     if (imem_ack) begin
                        pc <= next_pc;
                     end else begin
                        state  <= WAIT;
                        addr_q <= pc;
                     end
                  end
               end
               WAIT: begin
                  if (imem_ack) begin
                     pc    <= next_pc;
                     state <= FETCH;
                  end
               end
               DRAIN: begin
                  if (imem_ack) state <= FETCH;
               end
               default: state <= BOOT;
            endcase
         end
      end
   end

`ifdef FETCH_PERF_EN
   // Performance counters: delivered instructions and applied redirects.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_count    <= '0;
         redirect_count <= '0;
      end else begin
         if (if_load)  fetch_count    <= fetch_count + 32'd1;
         if (redirect) redirect_count <= redirect_count + 32'd1;
      end
   end
`endif

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Owns the architectural PC and sequences instruction fetch through a single-outstanding req/ack instruction-memory port.
- Applies EX-stage redirects (branch/jal target, jalr target) encoded with the core's 2-bit PC-source code.
- Flushes wrong-path fetches and traps misaligned targets.
- Sits between the EX-stage PC-source decode and the IF/ID pipeline register.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- TRAP_PC, 32'h0000_0100, PC loaded on a misaligned redirect target.
- XLEN, 32, address/data width; only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- redirect_valid  in  1  EX redirect qualifier for pc_src.
- pc_src  in  2  00 sequential (PC+4), 01 pc_tgt (branch/jal), 10 jalr_tgt, 11 treated as 00.
- pc_tgt  in  32  branch/jal target.
- jalr_tgt  in  32  raw jalr sum; bit0 is cleared internally.
- stall  in  1  hazard hold from the pipeline.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address.
- imem_ack  in  1  completes the request in the same cycle; imem_rdata is valid with it.
- imem_rdata  in  32  fetched instruction.
- if_valid  out  1  IF/ID entry valid.
- if_instr  out  32  fetched instruction.
- if_pc  out  32  PC of if_instr.
- flush  out  1  one-cycle pulse: kill the IF/ID entry and younger instructions.
- misalign_trap  out  1  one-cycle pulse on a misaligned redirect target.

Behaviour:
- Reset values (rst_n=0 at an edge):
  - pc=RESET_PC, state=BOOT.
  - imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, flush=0, misalign_trap=0.
  - Any outstanding request is abandoned; imem_req is low from the next cycle.
- States: BOOT, FETCH, WAIT, DRAIN.
  - BOOT: one idle cycle, then FETCH.
  - FETCH:
    - If stall=0: imem_req=1, imem_addr=pc.
    - Ack in the same cycle: if_valid/if_instr/if_pc load next edge (latency 1); pc<=pc+4 (mod 2^32); stay in FETCH.
    - No ack: go to WAIT.
    - If stall=1 and no request is outstanding: imem_req=0.
  - WAIT:
    - imem_req and imem_addr are held stable until ack; stall does not drop an outstanding request.
    - On ack: capture as in FETCH, then return to FETCH.
  - DRAIN:
    - Entered when a redirect arrives with a request outstanding, including a same-cycle ack.
    - Holds the request until ack, discards the returned data (if_valid stays 0), then goes to FETCH at the redirect PC.
    - In the same-cycle-ack case, drain completes immediately.
- IF/ID hold:
  - While stall=1, if_valid/if_instr/if_pc hold.
  - Ack data arriving during a stall is not lost: the request is not issued while stall=1 and no request is outstanding. An outstanding ack during a stall is buffered in a one-entry skid and presented when stall drops.
- Redirect (redirect_valid=1, pc_src in {01,10}):
  - target = pc_tgt, or {jalr_tgt[31:1],1'b0}.
  - If target[1:0]!=0: pc<=TRAP_PC and misalign_trap=1 for one cycle.
  - Else pc<=target.
  - flush=1 for one cycle; if_valid<=0 and the skid is cleared.
  - Redirect has priority over stall and over the sequential PC+4.
  - With no outstanding request: imem_addr=target in the next cycle.
- A redirect with pc_src=00 or 11 is ignored.
- A second redirect while in DRAIN overwrites the pending PC (latest wins); flush pulses again.

Optional Feature:
- FETCH_PERF_EN defined:
  - Adds out ports fetch_count[31:0] (accepted acks that produce if_valid) and redirect_count[31:0] (applied redirects).
  - Both counters reset to 0 and wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package pc_fetch_pkg:
  - XLEN.
  - PCSRC_SEQ=2'b00, PCSRC_TGT=2'b01, PCSRC_JALR=2'b10.
  - State typedef {BOOT, FETCH, WAIT, DRAIN}.
- Sub-module pc_next_sel: combinational next-PC mux plus the alignment check, producing next_pc and misaligned.

Test Plan:
- Reset release, ack every cycle -> imem_addr 0x0,0x4,0x8; if_pc follows one cycle later; if_valid=1 from the third cycle.
- Ack delayed 3 cycles at 0x4 -> imem_addr stays 0x4 with req=1 for 3 cycles; a single if_valid with if_pc=0x4.
- Redirect pc_src=01, pc_tgt=0x200 while WAIT at 0x10 -> flush pulse; 0x10 data discarded after ack; next imem_addr=0x200.
- pc_src=10, jalr_tgt=0x301 -> target 0x300, no trap.
- pc_src=01, pc_tgt=0x102 -> misalign_trap pulse; next imem_addr=TRAP_PC (0x100).
- stall=1 for 4 cycles with ack pending, then a redirect during the stall -> if outputs held; the redirect wins; no duplicate or lost if_valid.
- rst_n=0 mid-WAIT -> req=0 next cycle; imem_addr=0x0 after release.
